// File: rtl/c_bram_arbiter_if.sv
// rtl/c_bram_arbiter_if.sv - requester and BRAM C bus bundle for c_bram_arbiter
interface c_bram_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 4
);
  // compute-side writeback
  logic                  wr_req;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_gnt;
  // host-side readout
  logic                  rd_req;
  logic [AW-1:0]         rd_addr;
  logic                  rd_gnt;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  // BRAM C single port
  logic                  bram_en;
  logic                  bram_we;
  logic [AW-1:0]         bram_addr;
  logic [DATA_WIDTH-1:0] bram_wdata;
  logic [DATA_WIDTH-1:0] bram_rdata;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, bram_rdata,
    output wr_gnt, rd_gnt, rd_valid, rd_data, bram_en, bram_we, bram_addr, bram_wdata
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, bram_rdata,
    input  wr_gnt, rd_gnt, rd_valid, rd_data, bram_en, bram_we, bram_addr, bram_wdata
  );
endinterface

// File: rtl/c_bram_arbiter.sv
// rtl/c_bram_arbiter.sv - BRAM C port arbiter (round-robin; fixed write priority with C_ARB_WR_PRIORITY_EN)
module c_bram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int M          = 3,
  parameter int N          = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  c_bram_arbiter_if.slave      bus,
  input  logic                 clear,
  output logic                 all_written,
  output logic                 busy
);
  localparam int AW = $clog2(M*N);
  localparam int CW = $clog2(M*N+1);
  localparam logic [CW-1:0] TOTAL = CW'(M*N);

  logic                  wr_gnt;
  logic                  rd_gnt;
  logic                  bram_en_q, bram_en_d;
  logic                  bram_we_q, bram_we_d;
  logic [AW-1:0]         bram_addr_q, bram_addr_d;
  logic [DATA_WIDTH-1:0] bram_wdata_q, bram_wdata_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  busy_q, busy_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  all_written_q, all_written_d;
`ifndef C_ARB_WR_PRIORITY_EN
  logic                  rd_pri_q, rd_pri_d;
`endif

  // Grant selection: one grant per cycle, only to a requesting side
  always_comb begin
`ifdef C_ARB_WR_PRIORITY_EN
    wr_gnt = bus.wr_req;
    rd_gnt = bus.rd_req & ~bus.wr_req;
`else
    wr_gnt = bus.wr_req & (~bus.rd_req | ~rd_pri_q);
    rd_gnt = bus.rd_req & (~bus.wr_req |  rd_pri_q);
`endif
  end

  // Next-state: BRAM command, read pipeline, write counter, priority pointer
  always_comb begin
    bram_en_d    = 1'b0;
    bram_we_d    = 1'b0;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    if (wr_gnt) begin
      bram_en_d    = 1'b1;
      bram_we_d    = 1'b1;
      bram_addr_d  = bus.wr_addr;
      bram_wdata_d = bus.wr_data;
    end else if (rd_gnt) begin
      bram_en_d    = 1'b1;
      bram_addr_d  = bus.rd_addr;
    end
    rd_pend_d  = rd_gnt;
    rd_valid_d = rd_pend_q;
    busy_d     = rd_gnt | rd_pend_q;
    cnt_d         = cnt_q;
    all_written_d = all_written_q;
    if (clear) begin
      cnt_d         = '0;
      all_written_d = 1'b0;
    end else if (wr_gnt && cnt_q != TOTAL) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == TOTAL - 1'b1) all_written_d = 1'b1;
    end
`ifndef C_ARB_WR_PRIORITY_EN
    rd_pri_d = rd_pri_q;
    if (wr_gnt)      rd_pri_d = 1'b1;
    else if (rd_gnt) rd_pri_d = 1'b0;
`endif
  end

  // State registers; reset drops any in-flight read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_en_q     <= 1'b0;
      bram_we_q     <= 1'b0;
      bram_addr_q   <= '0;
      bram_wdata_q  <= '0;
      rd_pend_q     <= 1'b0;
      rd_valid_q    <= 1'b0;
      busy_q        <= 1'b0;
      cnt_q         <= '0;
      all_written_q <= 1'b0;
`ifndef C_ARB_WR_PRIORITY_EN
      rd_pri_q      <= 1'b0;
`endif
    end else begin
      bram_en_q     <= bram_en_d;
      bram_we_q     <= bram_we_d;
      bram_addr_q   <= bram_addr_d;
      bram_wdata_q  <= bram_wdata_d;
      rd_pend_q     <= rd_pend_d;
      rd_valid_q    <= rd_valid_d;
      busy_q        <= busy_d;
      cnt_q         <= cnt_d;
      all_written_q <= all_written_d;
`ifndef C_ARB_WR_PRIORITY_EN
      rd_pri_q      <= rd_pri_d;
`endif
    end
  end

  assign bus.wr_gnt     = wr_gnt;
  assign bus.rd_gnt     = rd_gnt;
  assign bus.bram_en    = bram_en_q;
  assign bus.bram_we    = bram_we_q;
  assign bus.bram_addr  = bram_addr_q;
  assign bus.bram_wdata = bram_wdata_q;
  assign bus.rd_valid   = rd_valid_q;
  // BRAM output register already holds the data; gate it so rd_data is 0 outside valid
  assign bus.rd_data    = rd_valid_q ? bus.bram_rdata : '0;
  assign all_written    = all_written_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_c_bram_arbiter.sv
// tb/tb_c_bram_arbiter.sv - directed self-checking bench for c_bram_arbiter
module tb_c_bram_arbiter;
  localparam int DW = 32;
  localparam int M  = 3;
  localparam int N  = 3;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic all_written;
  logic busy;
  int total = 0;
  int bad = 0;

  logic [DW-1:0] mem [0:15];
  logic [DW-1:0] rdata_q = '0;

  c_bram_arbiter_if #(.DATA_WIDTH(DW), .AW(AW)) bus ();

  c_bram_arbiter #(.DATA_WIDTH(DW), .M(M), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .clear(clear),
    .all_written(all_written), .busy(busy)
  );

  always #5 clk = ~clk;

  // synchronous single-port BRAM model
  assign bus.bram_rdata = rdata_q;
  always @(posedge clk) begin
    if (bus.bram_en) begin
      if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_wdata;
      else             rdata_q <= mem[bus.bram_addr];
    end
  end

  task automatic idle();
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    clear = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_wdata, bus.rd_valid, bus.rd_data,
         all_written, busy, bus.wr_gnt, bus.rd_gnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got en=%b we=%b addr=%h wd=%h rv=%b rd=%h aw=%b busy=%b wg=%b rg=%b exp all 0",
               bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_wdata, bus.rd_valid, bus.rd_data,
               all_written, busy, bus.wr_gnt, bus.rd_gnt);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_write_fill();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      bus.wr_req = 1'b1; bus.wr_addr = AW'(i); bus.wr_data = DW'(32'h3F800000 + i);
      @(negedge clk);
      total++;
      if (bus.wr_gnt !== 1'b1 || bus.rd_gnt !== 1'b0) begin
        bad++; $display("FAIL fill_gnt[%0d] got wg=%b rg=%b exp wg=1 rg=0", i, bus.wr_gnt, bus.rd_gnt);
      end
      if (i > 0) begin
        total++;
        if ({bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_wdata} !==
            {1'b1, 1'b1, AW'(i-1), DW'(32'h3F800000 + i - 1)}) begin
          bad++; $display("FAIL fill_bram[%0d] got en=%b we=%b addr=%h wd=%h exp 1 1 %h %h", i,
                          bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_wdata, i-1, 32'h3F800000 + i - 1);
        end
      end
      total++;
      if (all_written !== 1'b0) begin
        bad++; $display("FAIL fill_all_written_early[%0d] got %b exp 0", i, all_written);
      end
    end
    @(posedge clk); #1 idle();
    @(negedge clk);
    total++;
    if ({bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_wdata} !== {1'b1, 1'b1, AW'(8), 32'h3F800008}) begin
      bad++; $display("FAIL fill_bram_last got en=%b we=%b addr=%h wd=%h exp 1 1 8 3f800008",
                      bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_wdata);
    end
    total++;
    if (all_written !== 1'b1) begin
      bad++; $display("FAIL fill_all_written got %b exp 1", all_written);
    end
    @(negedge clk);
    total++;
    if ({bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_wdata, all_written} !==
        {1'b0, 1'b0, AW'(8), 32'h3F800008, 1'b1}) begin
      bad++; $display("FAIL idle_hold got en=%b we=%b addr=%h wd=%h aw=%b exp 0 0 8 3f800008 1",
                      bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_wdata, all_written);
    end
  endtask

  task automatic test_read_after_write();
    @(posedge clk); #1;
    bus.wr_req = 1'b1; bus.wr_addr = AW'(4); bus.wr_data = 32'h40490FDB;
    @(negedge clk);
    total++;
    if (bus.wr_gnt !== 1'b1) begin bad++; $display("FAIL raw_wr_gnt got %b exp 1", bus.wr_gnt); end
    @(posedge clk); #1;
    bus.wr_req = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = AW'(4);
    @(negedge clk);
    total++;
    if (bus.rd_gnt !== 1'b1 || bus.wr_gnt !== 1'b0) begin
      bad++; $display("FAIL raw_rd_gnt got rg=%b wg=%b exp rg=1 wg=0", bus.rd_gnt, bus.wr_gnt);
    end
    @(posedge clk); #1 bus.rd_req = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.rd_valid, busy, bus.bram_en, bus.bram_we, bus.bram_addr} !== {1'b0, 1'b1, 1'b1, 1'b0, AW'(4)}) begin
      bad++; $display("FAIL raw_t1 got rv=%b busy=%b en=%b we=%b addr=%h exp 0 1 1 0 4",
                      bus.rd_valid, busy, bus.bram_en, bus.bram_we, bus.bram_addr);
    end
    @(negedge clk);
    total++;
    if ({bus.rd_valid, busy, bus.rd_data} !== {1'b1, 1'b1, 32'h40490FDB}) begin
      bad++; $display("FAIL raw_t2 got rv=%b busy=%b rd=%h exp 1 1 40490fdb", bus.rd_valid, busy, bus.rd_data);
    end
    @(negedge clk);
    total++;
    if ({bus.rd_valid, busy} !== 2'b00) begin
      bad++; $display("FAIL raw_t3 got rv=%b busy=%b exp 0 0", bus.rd_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [0:1];
    exp_d[0] = 32'h3F800000;
    exp_d[1] = 32'h40490FDB;
    @(posedge clk); #1 bus.rd_req = 1'b1; bus.rd_addr = AW'(0);
    @(posedge clk); #1 bus.rd_addr = AW'(4);
    @(posedge clk); #1 bus.rd_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if ({bus.rd_valid, bus.rd_data} !== {1'b1, exp_d[k]}) begin
        bad++; $display("FAIL b2b_read[%0d] got rv=%b rd=%h exp 1 %h", k, bus.rd_valid, bus.rd_data, exp_d[k]);
      end
    end
    @(negedge clk);
    total++;
    if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail got rv=%b exp 0", bus.rd_valid); end
  endtask

  task automatic test_contention();
    logic exp_w;
    do_reset();
    @(posedge clk); #1;
    bus.wr_req = 1'b1; bus.wr_addr = AW'(1); bus.wr_data = 32'h3F800001;
    bus.rd_req = 1'b1; bus.rd_addr = AW'(0);
    for (int i = 0; i < 6; i++) begin
`ifdef C_ARB_WR_PRIORITY_EN
      exp_w = 1'b1;
`else
      exp_w = (i % 2 == 0);
`endif
      @(negedge clk);
      total++;
      if (bus.wr_gnt !== exp_w || bus.rd_gnt !== ~exp_w) begin
        bad++; $display("FAIL contend[%0d] got wg=%b rg=%b exp wg=%b rg=%b", i, bus.wr_gnt, bus.rd_gnt, exp_w, ~exp_w);
      end
    end
    @(posedge clk); #1 bus.wr_req = 1'b0;
    @(negedge clk);
    total++;
    if (bus.rd_gnt !== 1'b1 || bus.wr_gnt !== 1'b0) begin
      bad++; $display("FAIL contend_wr_drop got wg=%b rg=%b exp wg=0 rg=1", bus.wr_gnt, bus.rd_gnt);
    end
    @(posedge clk); #1 idle();
    repeat (3) @(posedge clk);
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.wr_req = 1'b1; bus.wr_addr = AW'(i); bus.wr_data = DW'(32'h3F800000 + i);
      clear = (i == 4);
      @(negedge clk);
      total++;
      if (bus.wr_gnt !== 1'b1) begin bad++; $display("FAIL clr_pre_gnt[%0d] got %b exp 1", i, bus.wr_gnt); end
    end
    @(posedge clk); #1 idle();
    @(negedge clk);
    total++;
    if (all_written !== 1'b0) begin bad++; $display("FAIL clr_after got %b exp 0", all_written); end
    for (int j = 0; j < 9; j++) begin
      @(posedge clk); #1;
      bus.wr_req = 1'b1; bus.wr_addr = AW'(j); bus.wr_data = DW'(32'h3F800000 + j);
      @(negedge clk);
      total++;
      if (all_written !== 1'b0) begin bad++; $display("FAIL clr_refill_early[%0d] got %b exp 0", j, all_written); end
    end
    @(posedge clk); #1 idle();
    @(negedge clk);
    total++;
    if (all_written !== 1'b1) begin bad++; $display("FAIL clr_refill_done got %b exp 1", all_written); end
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    total++;
    if (all_written !== 1'b0) begin bad++; $display("FAIL clr_alone got %b exp 0", all_written); end
  endtask

  task automatic test_reset_inflight();
    @(posedge clk); #1;
    bus.rd_req = 1'b1; bus.rd_addr = AW'(4);
    @(negedge clk);
    total++;
    if (bus.rd_gnt !== 1'b1) begin bad++; $display("FAIL rst_rd_gnt got %b exp 1", bus.rd_gnt); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    total++;
    if ({bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_wdata, bus.rd_valid, bus.rd_data,
         all_written, busy} !== '0) begin
      bad++; $display("FAIL rst_midop_outputs got en=%b we=%b addr=%h wd=%h rv=%b rd=%h aw=%b busy=%b exp all 0",
                      bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_wdata, bus.rd_valid, bus.rd_data,
                      all_written, busy);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rst_dropped_read[%0d] got rv=%b exp 0", k, bus.rd_valid); end
    end
  endtask

  initial begin
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    test_reset();
    test_write_fill();
    test_read_after_write();
    test_back_to_back();
    test_contention();
    test_clear();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
